// File: rtl/fifo_param.sv
// fifo_param: parametrised synchronous FIFO with occupancy count, programmable thresholds, flush and sticky error flags
module fifo_param #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 7,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  write,
  input  logic                  read,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  over,
  output logic                  under,
  output logic                  err_over,
  output logic                  err_under
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_N = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_N = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_N = (ADDR_WIDTH+1)'(AE_LEVEL);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic wr_ok, rd_ok;
  assign full = count == FULL_N;
  assign empty = count == '0;
  assign almost_full = count >= AF_N;
  assign almost_empty = count <= AE_N;
  assign wr_ok = write & ~full;
  assign rd_ok = read & ~empty;
  always_ff @(posedge clk)
    if (wr_ok && !clear) mem[wptr] <= din;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      dout <= '0;
      valid <= 1'b0;
      over <= 1'b0;
      under <= 1'b0;
      err_over <= 1'b0;
      err_under <= 1'b0;
    end else begin
      err_over <= (write & full & ~clear) | (err_over & ~err_clr);
      err_under <= (read & empty & ~clear) | (err_under & ~err_clr);
      if (clear) begin
        wptr <= '0;
        rptr <= '0;
        count <= '0;
        valid <= 1'b0;
        over <= 1'b0;
        under <= 1'b0;
      end else begin
        over <= write & full;
        under <= read & empty;
        valid <= rd_ok;
        if (rd_ok) dout <= mem[rptr];
        wptr <= wptr + ADDR_WIDTH'(wr_ok);
        rptr <= rptr + ADDR_WIDTH'(rd_ok);
        count <= count + (ADDR_WIDTH+1)'(wr_ok) - (ADDR_WIDTH+1)'(rd_ok);
      end
    end
endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: randomized and directed check of two fifo_param configurations against a queue model
module tb_fifo_param;
  localparam longint X = -1;
  logic clk = 0, reset_n = 0, clear = 0, write = 0, read = 0, err_clr = 0;
  logic [31:0] din = 0;
  logic [15:0] dout0;
  logic [31:0] dout1;
  logic [3:0] count0;
  logic [4:0] count1;
  logic [1:0] valid_v, full_v, af_v, empty_v, ae_v, over_v, under_v, eo_v, eu_v;
  int total = 0, bad = 0, cyc = 0;
  logic [31:0] q [2][$];
  logic [31:0] m_dout [2] = '{0, 0};
  logic [1:0] m_valid = 0, m_over = 0, m_under = 0, m_eo = 0, m_eu = 0;
  longint p_f [2][11];
  string p_name [2];
  int p_seq [2] = '{0, 0};
  int seen [2] = '{0, 0};
  string fname [11] = '{"count", "dout", "valid", "over", "under", "err_over", "err_under",
                        "full", "almost_full", "empty", "almost_empty"};

  always #5 clk = ~clk;

  fifo_param u0 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .write(write), .read(read),
    .din(din[15:0]), .err_clr(err_clr), .dout(dout0), .valid(valid_v[0]), .count(count0),
    .full(full_v[0]), .almost_full(af_v[0]), .empty(empty_v[0]), .almost_empty(ae_v[0]),
    .over(over_v[0]), .under(under_v[0]), .err_over(eo_v[0]), .err_under(eu_v[0])
  );

  fifo_param #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .AF_LEVEL(12), .AE_LEVEL(3)) u1 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .write(write), .read(read),
    .din(din), .err_clr(err_clr), .dout(dout1), .valid(valid_v[1]), .count(count1),
    .full(full_v[1]), .almost_full(af_v[1]), .empty(empty_v[1]), .almost_empty(ae_v[1]),
    .over(over_v[1]), .under(under_v[1]), .err_over(eo_v[1]), .err_under(eu_v[1])
  );

  function automatic int dep(int i); return i != 0 ? 16 : 8; endfunction
  function automatic int afl(int i); return i != 0 ? 12 : 7; endfunction
  function automatic int ael(int i); return i != 0 ? 3 : 1; endfunction

  always @(posedge clk or negedge reset_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        q[i].delete();
        m_dout[i] = 0;
        m_valid[i] = 0;
        m_over[i] = 0;
        m_under[i] = 0;
        m_eo[i] = 0;
        m_eu[i] = 0;
      end else begin
        bit fl, em;
        fl = q[i].size() == dep(i);
        em = q[i].size() == 0;
        m_eo[i] = (write & fl & ~clear) | (m_eo[i] & ~err_clr);
        m_eu[i] = (read & em & ~clear) | (m_eu[i] & ~err_clr);
        if (clear) begin
          q[i].delete();
          m_valid[i] = 0;
          m_over[i] = 0;
          m_under[i] = 0;
        end else begin
          m_over[i] = write & fl;
          m_under[i] = read & em;
          m_valid[i] = read & !em;
          if (read && !em) m_dout[i] = q[i].pop_front();
          if (write && !fl) q[i].push_back(i != 0 ? din : {16'h0, din[15:0]});
        end
      end
    end
  end

  function automatic longint mod_f(int i, int k);
    int n;
    n = q[i].size();
    case (k)
      0: return longint'(n);
      1: return longint'(m_dout[i]);
      2: return longint'(m_valid[i]);
      3: return longint'(m_over[i]);
      4: return longint'(m_under[i]);
      5: return longint'(m_eo[i]);
      6: return longint'(m_eu[i]);
      7: return longint'(n == dep(i));
      8: return longint'(n >= afl(i));
      9: return longint'(n == 0);
      default: return longint'(n <= ael(i));
    endcase
  endfunction

  function automatic longint dut_f(int i, int k);
    case (k)
      0: return i != 0 ? longint'(count1) : longint'(count0);
      1: return i != 0 ? longint'(dout1) : longint'(dout0);
      2: return longint'(valid_v[i]);
      3: return longint'(over_v[i]);
      4: return longint'(under_v[i]);
      5: return longint'(eo_v[i]);
      6: return longint'(eu_v[i]);
      7: return longint'(full_v[i]);
      8: return longint'(af_v[i]);
      9: return longint'(empty_v[i]);
      default: return longint'(ae_v[i]);
    endcase
  endfunction

  task automatic chk(string nm, int i, longint got, longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL cyc=%0d inst%0d %s got=%0h exp=%0h", cyc, i, nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 11; k++) chk(fname[k], i, dut_f(i, k), mod_f(i, k));
      if (p_seq[i] != seen[i]) begin
        seen[i] = p_seq[i];
        for (int k = 0; k < 11; k++)
          if (p_f[i][k] != X) begin
            chk({"pin ", p_name[i], "/", fname[k], " model"}, i, mod_f(i, k), p_f[i][k]);
            chk({"pin ", p_name[i], "/", fname[k], " dut"}, i, dut_f(i, k), p_f[i][k]);
          end
      end
    end
  end

  task automatic pin(input int i, input string nm, input longint c = X, d = X, v = X, ov = X,
                     un = X, eo = X, eu = X, fu = X, af = X, em = X, ae = X);
    p_name[i] = nm;
    p_f[i] = '{c, d, v, ov, un, eo, eu, fu, af, em, ae};
    p_seq[i]++;
  endtask

  task automatic step(input logic w, input logic r, input logic [31:0] d = 0,
                      input logic c = 0, input logic ec = 0);
    write = w;
    read = r;
    din = d;
    clear = c;
    err_clr = ec;
    @(posedge clk);
    #1;
    write = 0;
    read = 0;
    clear = 0;
    err_clr = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    pin(0, "reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    pin(1, "reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    @(posedge clk);
    #1;
    reset_n = 1;
    for (int n = 1; n <= 8; n++) begin
      step(1, 0, n);
      if (n == 7) pin(0, "af7", 7, X, X, X, X, X, X, 0, 1, 0, 0);
      if (n == 8) begin
        pin(0, "full8", 8, X, X, X, X, X, X, 1, 1, 0, 0);
        pin(1, "d16_8", 8, X, X, X, X, X, X, 0, 0, 0, 0);
      end
    end
    step(1, 0, 9);
    pin(0, "ovf", 8, X, X, 1, 0, 1, X, 1);
    step(0, 0);
    pin(0, "ovf_pulse", 8, X, X, 0, X, 1);
    for (int n = 1; n <= 8; n++) begin
      step(0, 1);
      pin(0, "rd", X, n, 1, X, 0, X, X, X, X, n == 8 ? 1 : 0);
    end
    step(0, 1);
    pin(0, "udf", 0, 8, 0, X, 1, X, 1, 0, 0, 1, 1);
    pin(1, "rd9", 0, 9, 1, X, 0);
    step(0, 0);
    pin(0, "udf_pulse", X, 8, 0, X, 0, X, 1);
    for (int n = 0; n < 8; n++) step(1, 0, 'h10 + n);
    step(1, 1, 'h0b0b);
    pin(0, "full_wr", 7, 'h10, 1, 1, 0);
    pin(1, "full_wr", 8, 'h10, 1, 0, 0);
    repeat (8) step(0, 1);
    step(0, 0);
    step(1, 1, 'h1234);
    pin(0, "empty_wr", 1, 'h17, 0, 0, 1, X, 1);
    pin(1, "empty_wr", 1, 'h0b0b, 0, 0, 1, X, 1);
    step(0, 1);
    pin(0, "fresh", 0, 'h1234, 1, 0, 0);
    pin(1, "fresh", 0, 'h1234, 1, 0, 0);
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 4; j++) step(1, 0, 'h100 + 4 * r + j);
      for (int j = 0; j < 4; j++) step(0, 1);
      pin(0, "wrap", 0, 'h100 + 4 * r + 3, 1);
      pin(1, "wrap", 0, 'h100 + 4 * r + 3, 1);
    end
    step(0, 0, 0, 0, 1);
    pin(0, "errclr", X, X, X, X, X, 0, 0);
    pin(1, "errclr", X, X, X, X, X, 0, 0);
    step(0, 1, 0, 0, 1);
    pin(0, "set_wins", 0, 'h10b, 0, 0, 1, 0, 1);
    for (int n = 0; n < 5; n++) step(1, 0, 'h200 + n);
    step(1, 0, 'h2ff, 1);
    pin(0, "clear", 0, 'h10b, 0, 0, 0, 0, 1, 0, 0, 1, 1);
    pin(1, "clear", 0, 'h10b, 0, 0, 0, 0, 1, 0, 0, 1, 1);
    for (int n = 1; n <= 16; n++) begin
      step(1, 0, 'h300 + n);
      if (n == 3) pin(1, "ae3", 3, X, X, X, X, X, X, 0, 0, 0, 1);
      if (n == 4) pin(1, "ae4", 4, X, X, X, X, X, X, 0, 0, 0, 0);
      if (n == 11) pin(1, "af11", 11, X, X, X, X, X, X, 0, 0, 0, 0);
      if (n == 12) pin(1, "af12", 12, X, X, X, X, X, X, 0, 1, 0, 0);
      if (n == 16) pin(1, "full16", 16, X, X, X, X, X, X, 1, 1, 0, 0);
    end
    step(1, 0, 'h3ff);
    pin(1, "ovf16", 16, X, X, 1, X, 1, X, 1);
    pin(0, "ovf8", 8, X, X, 1, X, 1, X, 1);
    step(0, 0, 0, 0, 1);
    pin(1, "errclr16", 16, X, X, 0, X, 0, 0);
    step(0, 0, 0, 1);
    for (int n = 1; n <= 3; n++) step(1, 0, 'h400 + n);
    write = 1;
    din = 'h404;
    #2;
    reset_n = 0;
    write = 0;
    pin(0, "async_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    pin(1, "async_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    @(posedge clk);
    #1;
    reset_n = 1;
    for (int c = 0; c < 3000; c++) begin
      bit wh;
      wh = ((c / 150) % 2) == 0;
      step($urandom_range(0, 99) < (wh ? 70 : 30), $urandom_range(0, 99) < (wh ? 30 : 70),
           $urandom, $urandom_range(0, 199) == 0, $urandom_range(0, 99) < 3);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
